regfile_wb_arbiter: RTL

- Shares the register file's single write port between NUM_REQ writeback sources, e.g. ALU, load unit and mul/div, using round-robin arbitration and a valid/ready handshake.
- Holds a per-register scoreboard. Issue logic reserves a destination register; the matching writeback clears it.
- Sits between the execute/memory writeback paths and the register file write port. Its outputs drive write_enable/write_addr/write_data directly from flops.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and sizing for the register-file writeback path.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  typedef struct packed {
    reg_addr_t addr;
    xlen_t     data;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, searching cyclically.
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);
  localparam int W = $clog2(N);

  int idx;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_idx   = W'(idx);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the register-file write port plus a per-register busy scoreboard.
module regfile_wb_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*XLEN-1:0]       req_data,
  input  logic                          rsv_valid,
  input  logic [REG_ADDR_W-1:0]         rsv_addr,
  input  logic [REG_ADDR_W-1:0]         chk_addr_1,
  input  logic [REG_ADDR_W-1:0]         chk_addr_2,
  output logic                          chk_busy_1,
  output logic                          chk_busy_2,
  output logic [31:0]                   busy_vec,
  output logic                          rf_write_enable,
  output logic [REG_ADDR_W-1:0]         rf_write_addr,
  output logic [XLEN-1:0]               rf_write_data
);
  import regfile_pkg::*;

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_t;

  wb_t                   req_s [NUM_REQ];
  wb_t                   win;
  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  handshake;
  logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  we_q;
  logic [REG_ADDR_W-1:0] wa_q;
  logic [XLEN-1:0]       wd_q;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_s[gi].addr = req_addr[gi*REG_ADDR_W +: REG_ADDR_W];
    assign req_s[gi].data = req_data[gi*XLEN +: XLEN];
  end

  // Masking requests with reset keeps ready low while reset is held.
  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req         (req_valid & {NUM_REQ{reset}}),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (handshake)
  );

  assign req_ready = grant;
  assign win       = req_s[grant_idx];

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (handshake)
      rr_ptr_d = (grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
  end

  // Clear before set so a same-cycle re-reservation of the written register survives.
  always_comb begin
    busy_d = busy_q;
    if (handshake) busy_d[win.addr] = 1'b0;
    if (rsv_valid) busy_d[rsv_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      busy_q   <= '0;
      we_q     <= 1'b0;
      wa_q     <= '0;
      wd_q     <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      busy_q   <= busy_d;
      we_q     <= handshake && (win.addr != '0);
      if (handshake) begin
        wa_q <= win.addr;
        wd_q <= win.data;
      end
    end
  end

  assign busy_vec        = busy_q;
  assign chk_busy_1      = busy_q[chk_addr_1];
  assign chk_busy_2      = busy_q[chk_addr_2];
  assign rf_write_enable = we_q;
  assign rf_write_addr   = wa_q;
  assign rf_write_data   = wd_q;
endmodule
